muldiv_unit: RTL and testbench

//  Iterative 32-bit integer multiply/divide unit for the DLX EX stage (MULT, MULTU, DIV, DIVU).
//  The EX stage is the initiator: it issues operands with a start pulse and stalls the pipe while busy.
//  The unit is the multi-cycle responder: it returns a 64-bit product or a quotient/remainder

---
 rtl/muldiv_unit.sv | 156 +++++++++++++++
 tb/tb_muldiv_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit for the DLX EX stage.
// It does one shift-add or restoring-divide step per cycle, then a sign fix-up, then a one-cycle done pulse.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result_lo,
    output logic [XLEN-1:0] result_hi,
    output logic            div_by_zero
);

    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [2*XLEN:0] acc_q, acc_d;
    logic [XLEN-1:0] opnd_q, opnd_d;
    logic            is_div_q, is_div_d;
    logic            neg_res_q, neg_res_d;
    logic            neg_rem_q, neg_rem_d;
    logic [XLEN-1:0] result_lo_q, result_lo_d;
    logic [XLEN-1:0] result_hi_q, result_hi_d;
    logic            dbz_q, dbz_d;

    logic            neg_a, neg_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [XLEN:0]   mul_sum;
    logic [2*XLEN:0] mul_next;
    logic [XLEN:0]   div_shift;
    logic [XLEN+1:0] div_diff;
    logic [2*XLEN:0] div_next;
    logic [2*XLEN-1:0] prod_fixed;
    logic [XLEN-1:0] quot_fixed, rem_fixed;

    assign neg_a = op[0] & a[XLEN-1];
    assign neg_b = op[0] & b[XLEN-1];
    assign mag_a = neg_a ? -a : a;
    assign mag_b = neg_b ? -b : b;

    // Multiply: the upper XLEN+1 bits accumulate, and the low half holds the multiplier and shifts out.
    assign mul_sum  = acc_q[2*XLEN:XLEN] + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {1'b0, mul_sum, acc_q[XLEN-1:1]};

    // Divide: the upper half is the partial remainder, and the low half shifts the dividend out and the quotient in.
    assign div_shift = acc_q[2*XLEN-1:XLEN-1];
    assign div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
    assign div_next  = {div_diff[XLEN+1] ? div_shift : div_diff[XLEN:0],
                        acc_q[XLEN-2:0], ~div_diff[XLEN+1]};

    assign prod_fixed = neg_res_q ? -acc_q[2*XLEN-1:0] : acc_q[2*XLEN-1:0];
    assign quot_fixed = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem_fixed  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    always_comb begin
        // NOTE: every _d starts from its _q so no path through this block can infer a latch.
        state_d     = state_q;
        count_d     = count_q;
        acc_d       = acc_q;
        opnd_d      = opnd_q;
        is_div_d    = is_div_q;
        neg_res_d   = neg_res_q;
        neg_rem_d   = neg_rem_q;
        result_lo_d = result_lo_q;
        result_hi_d = result_hi_q;
        dbz_d       = dbz_q;

        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    is_div_d  = op[1];
                    neg_res_d = op[0] & (a[XLEN-1] ^ b[XLEN-1]);
                    neg_rem_d = neg_a;
                    count_d   = '0;
                    if (op[1] && b == '0) begin
                        result_lo_d = '1;
                        result_hi_d = a;
                        dbz_d       = 1'b1;
                        state_d     = DONE;
                    end else begin
                        acc_d   = {{(XLEN+1){1'b0}}, op[1] ? mag_a : mag_b};
                        opnd_d  = op[1] ? mag_b : mag_a;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d   = is_div_q ? div_next : mul_next;
                    count_d = count_q + 1'b1;
                    if (count_q == CW'(XLEN - 1)) state_d = FIX;
                end
            end
            FIX: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    if (is_div_q) begin
                        result_lo_d = quot_fixed;
                        result_hi_d = rem_fixed;
                    end else begin
                        {result_hi_d, result_lo_d} = prod_fixed;
                    end
                    dbz_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            acc_q       <= '0;
            opnd_q      <= '0;
            is_div_q    <= 1'b0;
            neg_res_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            result_lo_q <= '0;
            result_hi_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            opnd_q      <= opnd_d;
            is_div_q    <= is_div_d;
            neg_res_q   <= neg_res_d;
            neg_rem_q   <= neg_rem_d;
            result_lo_q <= result_lo_d;
            result_hi_q <= result_hi_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign result_lo   = result_lo_q;
    assign result_hi   = result_hi_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit. It uses directed corner cases plus random operations,
// and checks them against a plain-arithmetic reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        flush = 1'b0;
    logic        busy, done, div_by_zero;
    logic [31:0] result_lo, result_hi;

    int n_checks = 0;
    int n_pass   = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .result_lo   (result_lo),
        .result_hi   (result_hi),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model: returns {hi, lo}.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, sq, sr;
        logic [63:0] ux, uy, r;
        ux = {32'd0, x};
        uy = {32'd0, y};
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r = '0;
        case (o)
            2'b00: r = ux * uy;
            2'b01: r = sx * sy;
            2'b10: r = (y == 0) ? {x, 32'hFFFF_FFFF} : {32'(ux % uy), 32'(ux / uy)};
            default: begin
                if (y == 0) r = {x, 32'hFFFF_FFFF};
                else begin
                    sq = sx / sy;
                    sr = sx % sy;
                    r = {32'(sr), 32'(sq)};
                end
            end
        endcase
        return r;
    endfunction

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int extra_starts);
        int lat;
        int extra;
        logic [63:0] exp;
        exp = model(o, x, y);
        extra = extra_starts;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
        lat = 1;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        while (!done && lat < 100) begin
            if (extra > 0 && busy) begin
                start = 1'b1; a = $urandom; b = $urandom; op = 2'($urandom);
                extra--;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check({tag, "_lat"}, 64'(lat), (o[1] && y == 0) ? 64'd1 : 64'd34);
        check({tag, "_res"}, {result_hi, result_lo}, exp);
        check({tag, "_dbz"}, 64'(div_by_zero), 64'(o[1] && y == 0));
        @(negedge clk);
        check({tag, "_pulse"}, 64'(done), 64'd0);
        check({tag, "_hold"}, {result_hi, result_lo}, exp);
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) n++;
        end
    endtask

    initial begin
        int n;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        #12;
        check("rst_state", {62'(0), busy, done}, 64'd0);
        check("rst_res", {result_hi, result_lo}, 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mult_neg", 2'b01, -32'sd3, 32'd7, 0);
        run_op("mult_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 0);
        run_op("div_neg", 2'b11, -32'sd7, 32'd2, 0);
        run_op("divu", 2'b10, 32'd100, 32'd7, 0);
        run_op("divu_zero", 2'b10, 32'd100, 32'd0, 0);
        run_op("divu_clr", 2'b10, 32'd100, 32'd7, 0);
        run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("div_zero", 2'b11, 32'h8000_0001, 32'd0, 0);
        run_op("extra_start", 2'b01, 32'h1234_5678, 32'hFEDC_BA98, 5);

        // Flush mid-run: there must be no done pulse, and the previous results must stay intact.
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        count_done(40, n);
        check("flush_nodone", 64'(n), 64'd0);
        check("flush_keep", {result_hi, result_lo}, model(2'b01, 32'h1234_5678, 32'hFEDC_BA98));
        run_op("after_flush", 2'b00, 32'd6, 32'd7, 0);

        // Start and flush together in IDLE: flush wins.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 2'b00; a = 32'd5; b = 32'd5;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("start_flush_idle", 64'(busy), 64'd0);

        // Reset mid-run.
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_mid_state", {62'(0), busy, done}, 64'd0);
        check("rst_mid_res", {result_hi, result_lo}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        count_done(40, n);
        check("rst_mid_nodone", 64'(n), 64'd0);
        run_op("after_rst", 2'b00, 32'd6, 32'd7, 0);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: ra = 32'h8000_0000;
                2: rb = 32'hFFFF_FFFF;
                3: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op("rand", ro, ra, rb, $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
